// File: rtl/mlp_seq_controller_pkg.sv
// Shared definitions for the MLP inference sequencer and its datapath.
// Holds the FSM state encoding, layer codes and default network sizes.
package mlp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        MAC,
        DRAIN,
        WB,
        CMP,
        DONE
    } state_t;

    localparam logic LAYER_HID = 1'b0;
    localparam logic LAYER_OUT = 1'b1;

    localparam int DEF_N_IN    = 62;
    localparam int DEF_N_HID   = 30;
    localparam int DEF_N_OUT   = 10;
    localparam int DEF_N_TEST  = 750;
    localparam int DEF_MAC_LAT = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mlp_seq_controller_if.sv
// Control bundle between the MLP sequencer (slave) and its user/datapath.
// master drives start/single/test_base/abort/match; slave drives the rest.
interface mlp_seq_controller_if #(
    parameter int IW = 1,
    parameter int NW = 1,
    parameter int TW = 1
);
    logic          start;
    logic          single;
    logic [TW-1:0] test_base;
    logic          abort;
    logic          match;
    logic          busy;
    logic          done;
    logic          layer;
    logic [IW-1:0] in_idx;
    logic [NW-1:0] neu_idx;
    logic [TW-1:0] test_idx;
    logic          acc_clr;
    logic          acc_en;
    logic          hid_wr;
    logic          out_wr;
    logic          cmp_en;
    logic [TW-1:0] cor_cnt;

    modport master (
        output start, single, test_base, abort, match,
        input  busy, done, layer, in_idx, neu_idx, test_idx,
        input  acc_clr, acc_en, hid_wr, out_wr, cmp_en, cor_cnt
    );

    modport slave (
        input  start, single, test_base, abort, match,
        output busy, done, layer, in_idx, neu_idx, test_idx,
        output acc_clr, acc_en, hid_wr, out_wr, cmp_en, cor_cnt
    );
endinterface

// File: rtl/mlp_seq_controller_counter.sv
// Index counter with clear/load/enable (priority in that order).
// Ports: clk, rst, clr_i, load_i, load_val_i, en_i, term_i -> q_o, last_o.
module mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] q_o,
    output logic             last_o
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i)
            q_d = '0;
        else if (load_i)
            q_d = load_val_i;
        else if (en_i)
            q_d = q_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o    = q_q;
    assign last_o = (q_q == term_i);
endmodule

// File: rtl/mlp_seq_controller.sv
// Sequencer for the two-layer MLP: walks samples/neurons/fan-in and strobes.
// Ports: clk, rst, bus (slave modport of mlp_seq_controller_if).
module mlp_seq_controller
    import mlp_ctrl_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_HID   = DEF_N_HID,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int N_TEST  = DEF_N_TEST,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input logic clk,
    input logic rst,
    mlp_seq_controller_if.slave bus
);
    localparam int IW = max2(1, $clog2(max2(N_IN, N_HID)));
    localparam int NW = max2(1, $clog2(max2(N_HID, N_OUT)));
    localparam int TW = $clog2(N_TEST + 1);
    localparam int DW = max2(1, $clog2(MAC_LAT + 1));
    localparam logic [DW-1:0] DLAST = DW'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);

    state_t        state_q, state_d;
    logic          layer_q, layer_d;
    logic          single_q, single_d;
    logic [TW-1:0] cor_q, cor_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    logic          in_clr, in_en, in_last;
    logic          neu_clr, neu_en, neu_last;
    logic          t_load, t_en, t_last;
    logic [IW-1:0] in_q, in_term;
    logic [NW-1:0] neu_q, neu_term;
    logic [TW-1:0] t_q, t_base;

    // Fan-in and neuron count depend on which layer is being computed
    assign in_term  = (layer_q == LAYER_OUT) ? IW'(N_HID - 1) : IW'(N_IN - 1);
    assign neu_term = (layer_q == LAYER_OUT) ? NW'(N_OUT - 1) : NW'(N_HID - 1);

    // Out-of-range single-sample base is clamped to the last sample
    always_comb begin
        t_base = '0;
        if (bus.single)
            t_base = (bus.test_base >= TW'(N_TEST)) ? TW'(N_TEST - 1)
                                                    : bus.test_base;
    end

    mod_counter #(.WIDTH(IW)) u_in (
        .clk(clk), .rst(rst),
        .clr_i(in_clr), .load_i(1'b0), .load_val_i('0),
        .en_i(in_en), .term_i(in_term),
        .q_o(in_q), .last_o(in_last)
    );

    mod_counter #(.WIDTH(NW)) u_neu (
        .clk(clk), .rst(rst),
        .clr_i(neu_clr), .load_i(1'b0), .load_val_i('0),
        .en_i(neu_en), .term_i(neu_term),
        .q_o(neu_q), .last_o(neu_last)
    );

    mod_counter #(.WIDTH(TW)) u_test (
        .clk(clk), .rst(rst),
        .clr_i(1'b0), .load_i(t_load), .load_val_i(t_base),
        .en_i(t_en), .term_i(TW'(N_TEST - 1)),
        .q_o(t_q), .last_o(t_last)
    );

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        single_d = single_q;
        cor_d    = cor_q;
        dcnt_d   = dcnt_q;
        in_clr   = 1'b0;
        in_en    = 1'b0;
        neu_clr  = 1'b0;
        neu_en   = 1'b0;
        t_load   = 1'b0;
        t_en     = 1'b0;
        // abort freezes all counters so their values stay visible for debug
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        cor_d    = '0;
                        layer_d  = LAYER_HID;
                        single_d = bus.single;
                        neu_clr  = 1'b1;
                        t_load   = 1'b1;
                        state_d  = CLR;
                    end
                end
                CLR: begin
                    in_clr  = 1'b1;
                    state_d = MAC;
                end
                MAC: begin
                    if (in_last) begin
                        dcnt_d  = '0;
                        state_d = (MAC_LAT == 0) ? WB : DRAIN;
                    end else begin
                        in_en = 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt_q == DLAST)
                        state_d = WB;
                    else
                        dcnt_d = dcnt_q + 1'b1;
                end
                WB: begin
                    if (!neu_last) begin
                        neu_en  = 1'b1;
                        state_d = CLR;
                    end else if (layer_q == LAYER_HID) begin
                        layer_d = LAYER_OUT;
                        neu_clr = 1'b1;
                        state_d = CLR;
                    end else begin
                        state_d = CMP;
                    end
                end
                CMP: begin
                    if (bus.match && cor_q != '1)
                        cor_d = cor_q + 1'b1;
                    if (single_q || t_last) begin
                        state_d = DONE;
                    end else begin
                        t_en    = 1'b1;
                        layer_d = LAYER_HID;
                        neu_clr = 1'b1;
                        state_d = CLR;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            layer_q  <= LAYER_HID;
            single_q <= 1'b0;
            cor_q    <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            single_q <= single_d;
            cor_q    <= cor_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign bus.busy     = (state_q != IDLE) && (state_q != DONE);
    assign bus.done     = (state_q == DONE);
    assign bus.layer    = layer_q;
    assign bus.in_idx   = in_q;
    assign bus.neu_idx  = neu_q;
    assign bus.test_idx = t_q;
    assign bus.acc_clr  = (state_q == CLR);
    assign bus.acc_en   = (state_q == MAC);
    assign bus.hid_wr   = (state_q == WB) && (layer_q == LAYER_HID);
    assign bus.out_wr   = (state_q == WB) && (layer_q == LAYER_OUT);
    assign bus.cmp_en   = (state_q == CMP);
    assign bus.cor_cnt  = cor_q;
endmodule

// File: tb/tb_mlp_seq_controller.sv
// Directed bench for mlp_seq_controller (4/3/2/2 network, MAC_LAT 1 and 0).
// Two DUT instances share clk/rst; each has its own control interface.
module tb_mlp_seq_controller;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mlp_seq_controller_if #(.IW(2), .NW(2), .TW(2)) bus0 ();
    mlp_seq_controller_if #(.IW(2), .NW(2), .TW(2)) bus1 ();

    mlp_seq_controller #(
        .N_IN(4), .N_HID(3), .N_OUT(2), .N_TEST(2), .MAC_LAT(1)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    mlp_seq_controller #(
        .N_IN(4), .N_HID(3), .N_OUT(2), .N_TEST(2), .MAC_LAT(0)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mmode 0: match left as set; 1: match only on the first cmp_en
    task automatic run0(input int mmode, input int start_at,
                        input int want_t, output int k,
                        output int nacc, output int nhid,
                        output int nout, output int ncmp,
                        output int tbad);
        int seen;
        seen = 0;
        k = 0; nacc = 0; nhid = 0; nout = 0; ncmp = 0; tbad = 0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        while (!bus0.done && k < 200) begin
            if (bus0.acc_en) nacc++;
            if (bus0.hid_wr) nhid++;
            if (bus0.out_wr) nout++;
            if (bus0.cmp_en) begin
                ncmp++;
                if (mmode == 1) bus0.match = (seen == 0);
                seen++;
            end
            if (want_t >= 0 && int'(bus0.test_idx) != want_t) tbad++;
            bus0.start = (k == start_at);
            tick();
            k++;
        end
        bus0.start = 1'b0;
    endtask

    task automatic run1(input logic sgl, output int k);
        k = 0;
        bus1.single = sgl;
        bus1.start  = 1'b1;
        tick();
        bus1.start  = 1'b0;
        while (!bus1.done && k < 200) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int k, na, nh, no, nc, tb;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus0.start = 0; bus0.single = 0; bus0.test_base = 0;
        bus0.abort = 0; bus0.match = 1;
        bus1.start = 0; bus1.single = 0; bus1.test_base = 0;
        bus1.abort = 0; bus1.match = 1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_busy", bus0.busy, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_strobes", {bus0.acc_clr, bus0.acc_en, bus0.hid_wr,
                            bus0.out_wr, bus0.cmp_en}, 0);
        chk("rst_idx", {bus0.layer, bus0.in_idx, bus0.neu_idx,
                        bus0.test_idx, bus0.cor_cnt}, 0);

        // Full batch, match tied high, stray start mid-run
        run0(0, 10, -1, k, na, nh, no, nc, tb);
        chk("b_lat", k, 68);
        chk("b_done", bus0.done, 1);
        chk("b_cor", bus0.cor_cnt, 2);
        chk("b_acc", na, 36);
        chk("b_hid", nh, 6);
        chk("b_out", no, 4);
        chk("b_cmp", nc, 2);
        chk("b_fin_layer", bus0.layer, 1);
        chk("b_fin_neu", bus0.neu_idx, 1);
        chk("b_fin_test", bus0.test_idx, 1);
        chk("b_fin_in", bus0.in_idx, 2);
        tick();
        chk("b_done_pulse", bus0.done, 0);
        chk("b_idle_busy", bus0.busy, 0);
        chk("b_idle_cor", bus0.cor_cnt, 2);

        // Only the first sample matches
        run0(1, -1, -1, k, na, nh, no, nc, tb);
        chk("m_lat", k, 68);
        chk("m_cor", bus0.cor_cnt, 1);
        bus0.match = 1'b1;
        tick();

        // Single sample at index 1
        bus0.single = 1'b1;
        bus0.test_base = 2'd1;
        run0(0, -1, 1, k, na, nh, no, nc, tb);
        chk("s_lat", k, 34);
        chk("s_tidx", tb, 0);
        chk("s_cmp", nc, 1);
        chk("s_cor", bus0.cor_cnt, 1);
        tick();

        // Single sample with out-of-range base clamps to last sample
        bus0.test_base = 2'd3;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        chk("c_tidx", bus0.test_idx, 1);
        chk("c_busy", bus0.busy, 1);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        bus0.single = 1'b0;
        bus0.test_base = 2'd0;
        chk("c_abort_busy", bus0.busy, 0);

        // abort with start in IDLE: start ignored
        bus0.abort = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.abort = 1'b0;
        bus0.start = 1'b0;
        chk("as_busy0", bus0.busy, 0);
        tick();
        chk("as_busy1", bus0.busy, 0);

        // Abort during the second sample's MAC
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        k = 0;
        while (!(bus0.test_idx == 2'd1 && bus0.acc_en) && k < 200) begin
            tick();
            k++;
        end
        chk("ab_reach", bus0.acc_en, 1);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk("ab_busy", bus0.busy, 0);
        chk("ab_acc", bus0.acc_en, 0);
        chk("ab_cor", bus0.cor_cnt, 1);
        chk("ab_tidx", bus0.test_idx, 1);
        nc = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus0.done || bus0.busy) nc++;
            tick();
        end
        chk("ab_quiet", nc, 0);
        run0(0, -1, -1, k, na, nh, no, nc, tb);
        chk("ab_rerun_lat", k, 68);
        chk("ab_rerun_cor", bus0.cor_cnt, 2);
        tick();

        // MAC_LAT = 0 instance
        run1(1'b0, k);
        chk("z_batch_lat", k, 58);
        chk("z_batch_cor", bus1.cor_cnt, 2);
        tick();
        run1(1'b1, k);
        chk("z_single_lat", k, 29);
        bus1.single = 1'b0;
        tick();

        // Asynchronous reset during WB
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        k = 0;
        while (!(bus0.hid_wr && bus0.test_idx == 2'd0 && bus0.neu_idx == 2'd1)
               && k < 200) begin
            tick();
            k++;
        end
        chk("r_reach", bus0.hid_wr, 1);
        #2 rst = 1'b1;
        #1;
        chk("r_busy", bus0.busy, 0);
        chk("r_strobes", {bus0.acc_clr, bus0.acc_en, bus0.hid_wr,
                          bus0.out_wr, bus0.cmp_en, bus0.done}, 0);
        chk("r_idx", {bus0.layer, bus0.in_idx, bus0.neu_idx,
                      bus0.test_idx, bus0.cor_cnt}, 0);
        #2 rst = 1'b0;
        tick();
        chk("r_after", bus0.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mlp_seq_controller.md
Name: mlp_seq_controller

Overview:
- Parametrised sequencer for the two-layer MLP inference datapath.
- Walks test samples, hidden neurons, output neurons and fan-in inputs internally. Drives accumulator, write-back and compare strobes. Counts correct classifications.
- Supersedes the fixed-size controller that used external up/rst counter loops. Adds a start/done/abort handshake, single-sample mode and a configurable MAC pipeline drain.

Parameters:
- N_IN, 62: inputs per sample, the hidden-layer fan-in (≥1).
- N_HID, 30: hidden neurons, the output-layer fan-in (≥1).
- N_OUT, 10: output neurons (≥1).
- N_TEST, 750: samples per batch run (≥1).
- MAC_LAT, 1: MAC pipeline cycles to wait after the last acc_en (≥0).
- Derived localparams, never overridden:
  - IW = $clog2(max(N_IN,N_HID)) ≥ 1
  - NW = $clog2(max(N_HID,N_OUT)) ≥ 1
  - TW = $clog2(N_TEST+1)

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- single  in  1  sampled with start; 1 = process only sample test_base.
- test_base  in  TW  first sample index used in single mode.
- abort  in  1  return to IDLE next cycle.
- match  in  1  datapath argmax equals label; valid while cmp_en=1.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse at normal completion.
- layer  out  1  0 = hidden layer, 1 = output layer (replaces HO_sel).
- in_idx  out  IW  current fan-in index (input or hidden-activation select).
- neu_idx  out  NW  current neuron within layer.
- test_idx  out  TW  current sample.
- acc_clr  out  1  clear accumulator.
- acc_en  out  1  accumulate the product at in_idx.
- hid_wr  out  1  store activation of hidden neuron neu_idx.
- out_wr  out  1  store value of output neuron neu_idx.
- cmp_en  out  1  compare strobe.
- cor_cnt  out  TW  correct-classification count.

Behaviour:
- Reset: state=IDLE, all strobes=0, busy=0, done=0, layer=0, all indices=0, cor_cnt=0.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- IDLE: on start=1 go to CLR with these updates at the accepting edge:
  - cor_cnt←0, layer←0, neu_idx←0.
  - test_idx←test_base when single=1, else 0.
  - single latched.
- CLR, 1 cycle: acc_clr=1, in_idx←0. Next state is MAC.
- MAC, FAN cycles: FAN=N_IN if layer=0, N_HID if layer=1.
  - acc_en=1 every cycle; in_idx counts 0..FAN-1.
  - On the cycle in_idx=FAN-1: go to DRAIN, or to WB if MAC_LAT=0.
- DRAIN, MAC_LAT cycles: all strobes 0. Then WB.
- WB, 1 cycle: hid_wr=1 if layer=0, else out_wr=1.
  - Not last neuron of layer: neu_idx++ → CLR.
  - Last hidden neuron: layer←1, neu_idx←0 → CLR.
  - Last output neuron: → CMP.
- CMP, 1 cycle: cmp_en=1.
  - If match=1, cor_cnt++; saturates at 2^TW-1.
  - If single is latched, or test_idx=N_TEST-1: → DONE.
  - Otherwise test_idx++, layer←0, neu_idx←0 → CLR.
- DONE, 1 cycle: done=1. → IDLE.
- Indices and cor_cnt hold their final values in IDLE.
- Per-sample latency:
  - N_HID·(N_IN+MAC_LAT+2) + N_OUT·(N_HID+MAC_LAT+2) + 1 cycles.
  - done appears in the cycle after the last sample's CMP.
- abort=1 in any non-IDLE state: next state is IDLE, no done pulse, strobes drop at that edge. cor_cnt and indices are retained for debug. abort has priority over all other transitions.
- abort=1 in IDLE has no effect. abort with start in IDLE: abort wins, start is ignored.
- start while not IDLE: ignored, the run is not restarted.
- test_base ≥ N_TEST in single mode: clamp to N_TEST-1.
- Asynchronous rst mid-run: immediate return to reset values.

Decomposition:
- Shared package mlp_ctrl_pkg:
  - State encoding localparams: IDLE, CLR, MAC, DRAIN, WB, CMP, DONE.
  - Layer codes: LAYER_HID=0, LAYER_OUT=1.
  - Default network-size constants shared with the datapath.
- Sub-module mod_counter(WIDTH), instantiated for in_idx, neu_idx and test_idx.
  - Inputs: clr, load, load_val, en.
  - Output: last, from a runtime terminal-value input.

Test Plan:
- Params N_IN=4, N_HID=3, N_OUT=2, N_TEST=2, MAC_LAT=1, single=0, match tied 1, one start pulse:
  - 34 cycles per sample; done is high exactly 68 cycles after the accepting edge.
  - cor_cnt=2; acc_en total 2·(3·4+2·3)=36 cycles.
  - hid_wr 6 pulses, out_wr 4 pulses, cmp_en 2 pulses.
- Same params, match=1 only on the first cmp_en → cor_cnt=1 after done.
- single=1, test_base=1 → test_idx=1 throughout, exactly one cmp_en, done 34 cycles after start.
- MAC_LAT=0 → the DRAIN state never appears; per-sample latency is 29 cycles.
- abort asserted during the second sample's MAC:
  - busy=0 next cycle, no done pulse, cor_cnt keeps its value from the first sample.
  - A following start runs normally and clears cor_cnt.
- rst pulsed asynchronously mid-WB → all outputs return to reset values immediately; start pulsed during busy is ignored.
